// File: rtl/emg_stim_sequencer.sv
// Steps a channel select across NUM_CH electrodes with programmable dwell, scan mode and frame count.
// It emits a one-cycle start pulse at the beginning of every dwell and a frame_done pulse on the last cycle of each frame.
//
// state | meaning
// IDLE  | waiting for En; the configuration is latched on the start edge
// RUN   | stepping channels, busy=1
// DONE  | finite frame count reached; waits for En=0 before going back to IDLE
module emg_stim_sequencer #(
   parameter int NUM_CH  = 16,
   parameter int CH_W    = 4,
   parameter int DWELL_W = 8,
   parameter int FRAME_W = 8
) (
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic               En,
   input  logic [1:0]         Mode,
   input  logic [NUM_CH-1:0]  Ch_Mask,
   input  logic [CH_W-1:0]    Hold_Ch,
   input  logic [DWELL_W-1:0] Dwell,
   input  logic [FRAME_W-1:0] Num_Frames,
   output logic [CH_W-1:0]    CH_Sel,
   output logic               start,
   output logic               frame_done,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [1:0]      M_ALL  = 2'b00;
   localparam logic [1:0]      M_MASK = 2'b01;
   localparam logic [1:0]      M_HOLD = 2'b10;
   localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

   function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
      lowest_set = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest_set = CH_W'(i);
   endfunction

   function automatic logic [CH_W-1:0] highest_set(input logic [NUM_CH-1:0] m);
      highest_set = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (m[i]) highest_set = CH_W'(i);
   endfunction

   function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] m,
                                                input logic [CH_W-1:0]   cur);
      next_set = lowest_set(m);
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i] && (CH_W'(i) > cur)) next_set = CH_W'(i);
   endfunction

   state_t               state_q, state_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 start_d, fd_d, busy_d;
   logic                 stop_q, stop_d;
   logic                 start_q, fd_q, busy_q;

   logic [1:0]           mode_q, mode_c;
   logic [NUM_CH-1:0]    mask_q, mask_c;
   logic [CH_W-1:0]      hold_q, hold_c;
   logic [DWELL_W-1:0]   dlast_q, dlast_c;
   logic [FRAME_W-1:0]   nf_q, nf_c;
   logic [CH_W-1:0]      hi_c, first_c;
   logic [FRAME_W-1:0]   fc_inc;
   logic                 last_cur, last_nxt;

   always_comb begin
      // While IDLE the live inputs are the configuration; afterwards the latched copy is used.
      if (state_q == IDLE) begin
         mode_c  = (Mode == 2'b11) ? M_ALL : Mode;
         mask_c  = Ch_Mask;
         hold_c  = (int'({1'b0, Hold_Ch}) >= NUM_CH) ? CH_MAX : Hold_Ch;
         dlast_c = (Dwell == '0) ? '0 : Dwell - DWELL_W'(1);
         nf_c    = Num_Frames;
      end else begin
         mode_c  = mode_q;
         mask_c  = mask_q;
         hold_c  = hold_q;
         dlast_c = dlast_q;
         nf_c    = nf_q;
      end
      hi_c = highest_set(mask_c);
      case (mode_c)
         M_MASK:  first_c = lowest_set(mask_c);
         M_HOLD:  first_c = hold_c;
         default: first_c = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      cnt_d    = cnt_q;
      frame_d  = frame_q;
      stop_d   = 1'b0;
      fc_inc   = frame_q + FRAME_W'(1);
      last_cur = (mode_c == M_HOLD) || (mode_c == M_MASK ? (ch_q == hi_c) : (ch_q == CH_MAX));

      case (state_q)
         IDLE: begin
            if (En && !(mode_c == M_MASK && mask_c == '0)) begin
               state_d = RUN;
               ch_d    = first_c;
               cnt_d   = '0;
               frame_d = '0;
            end
         end
         RUN: begin
            stop_d = stop_q || !En;
            if (cnt_q == dlast_c) begin
               cnt_d = '0;
               if (last_cur) frame_d = fc_inc;
               if (last_cur && nf_c != '0 && fc_inc == nf_c) begin
                  state_d = DONE;
               end else if (stop_d) begin
                  state_d = IDLE;
               end else begin
                  case (mode_c)
                     M_MASK:  ch_d = next_set(mask_c, ch_q);
                     M_HOLD:  ch_d = ch_q;
                     default: ch_d = (ch_q == CH_MAX) ? '0 : ch_q + CH_W'(1);
                  endcase
               end
            end else begin
               cnt_d = cnt_q + DWELL_W'(1);
            end
         end
         DONE: begin
            if (!En) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are derived from the next-state values.
      last_nxt = (mode_c == M_HOLD) || (mode_c == M_MASK ? (ch_d == hi_c) : (ch_d == CH_MAX));
      busy_d   = (state_d == RUN);
      start_d  = busy_d && (cnt_d == '0);
      fd_d     = busy_d && (cnt_d == dlast_c) && last_nxt;
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
         stop_q  <= 1'b0;
         start_q <= 1'b0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
         mode_q  <= M_ALL;
         mask_q  <= '0;
         hold_q  <= '0;
         dlast_q <= '0;
         nf_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         stop_q  <= stop_d;
         start_q <= start_d;
         fd_q    <= fd_d;
         busy_q  <= busy_d;
         if (state_q == IDLE && En) begin
            mode_q  <= mode_c;
            mask_q  <= mask_c;
            hold_q  <= hold_c;
            dlast_q <= dlast_c;
            nf_q    <= nf_c;
         end
      end
   end

   assign CH_Sel     = ch_q;
   assign start      = start_q;
   assign frame_done = fd_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_emg_stim_sequencer.sv
// Directed bench for emg_stim_sequencer: scan modes, dwell, frame count, stop, reset and config freeze.
module tb_emg_stim_sequencer;

   logic        CLK = 1'b0;
   logic        Reset_n;
   logic        En;
   logic [1:0]  Mode;
   logic [15:0] Ch_Mask;
   logic [3:0]  Hold_Ch;
   logic [7:0]  Dwell;
   logic [7:0]  Num_Frames;
   logic [3:0]  CH_Sel;
   logic        start;
   logic        frame_done;
   logic        busy;

   int errors = 0;
   int checks = 0;

   emg_stim_sequencer #(.NUM_CH(16), .CH_W(4), .DWELL_W(8), .FRAME_W(8)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .En(En), .Mode(Mode), .Ch_Mask(Ch_Mask),
      .Hold_Ch(Hold_Ch), .Dwell(Dwell), .Num_Frames(Num_Frames),
      .CH_Sel(CH_Sel), .start(start), .frame_done(frame_done), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int ch, input int st, input int fd, input int bz);
      chk({tag, "_ch"},    int'(CH_Sel),     ch);
      chk({tag, "_start"}, int'(start),      st);
      chk({tag, "_fd"},    int'(frame_done), fd);
      chk({tag, "_busy"},  int'(busy),       bz);
   endtask

   initial begin
      int seq2 [4];
      seq2 = '{0, 5, 10, 15};

      Reset_n = 1'b0; En = 1'b0; Mode = 2'b00; Ch_Mask = '0; Hold_Ch = '0;
      Dwell = '0; Num_Frames = '0;
      #12;
      chk_out("reset", 0, 0, 0, 0);
      @(negedge CLK);
      Reset_n = 1'b1;

      // 1: full scan, dwell 13, continuous
      Mode = 2'b00; Dwell = 8'd13; Num_Frames = 8'd0; En = 1'b1;
      for (int c = 0; c <= 208; c++) begin
         tick();
         chk_out("t1", (c / 13) % 16, int'(c % 13 == 0),
                 int'(c % 13 == 12 && (c / 13) % 16 == 15), 1);
      end
      En = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      chk_out("t1_lastdwell", 0, 0, 0, 1);
      tick();
      chk_out("t1_stop", 0, 0, 0, 0);

      // 2: masked scan 0,5,10,15 twice, dwell 4
      Mode = 2'b01; Ch_Mask = 16'h8421; Dwell = 8'd4; Num_Frames = 8'd2; En = 1'b1;
      for (int c = 0; c < 32; c++) begin
         tick();
         chk_out("t2", seq2[(c / 4) % 4], int'(c % 4 == 0), int'(c % 4 == 3 && (c / 4) % 4 == 3), 1);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_out("t2_done", 15, 0, 0, 0);
      end
      En = 1'b0;
      tick();

      // 3: hold channel 7, dwell 1, three frames
      Mode = 2'b10; Hold_Ch = 4'd7; Dwell = 8'd1; Num_Frames = 8'd3; En = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_out("t3", 7, 1, 1, 1);
      end
      tick();
      chk_out("t3_done", 7, 0, 0, 0);
      En = 1'b0;
      tick();

      // 4: graceful stop at dwell counter 2 of channel 3
      Mode = 2'b00; Dwell = 8'd5; Num_Frames = 8'd0; En = 1'b1;
      for (int c = 0; c <= 17; c++) tick();
      chk_out("t4_pre", 3, 0, 0, 1);
      En = 1'b0;
      tick();
      chk_out("t4_c3", 3, 0, 0, 1);
      tick();
      chk_out("t4_c4", 3, 0, 0, 1);
      tick();
      chk_out("t4_idle", 3, 0, 0, 0);
      tick();
      chk_out("t4_idle2", 3, 0, 0, 0);

      // 5: async reset mid-dwell of channel 9, restart, then empty mask
      En = 1'b1;
      for (int c = 0; c <= 47; c++) tick();
      chk_out("t5_pre", 9, 0, 0, 1);
      #2;
      Reset_n = 1'b0;
      #1;
      chk_out("t5_rst", 0, 0, 0, 0);
      @(negedge CLK);
      Reset_n = 1'b1;
      tick();
      chk_out("t5_restart", 0, 1, 0, 1);
      #2;
      Reset_n = 1'b0;
      Mode = 2'b01; Ch_Mask = 16'h0000;
      @(negedge CLK);
      Reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t5_nomask_busy", int'(busy), 0);
         chk("t5_nomask_start", int'(start), 0);
      end
      En = 1'b0;
      tick();

      // 6: config changes during RUN are ignored
      Mode = 2'b00; Dwell = 8'd3; Num_Frames = 8'd1; En = 1'b1;
      tick();
      chk_out("t6_first", 0, 1, 0, 1);
      Mode = 2'b10; Dwell = 8'd1; Hold_Ch = 4'd2; Num_Frames = 8'd0;
      for (int c = 1; c < 48; c++) begin
         tick();
         chk_out("t6", c / 3, int'(c % 3 == 0), int'(c == 47), 1);
      end
      tick();
      chk_out("t6_done", 15, 0, 0, 0);
      En = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
